execute_stage: RTL and testbench

Execute stage of the pipelined Y86-64 core, directly upstream of the memory stage. Computes valE with the ALU and evaluates the jump/cmov condition against the condition-code register (ZF/SF/OF). Updates the condition codes on OPq. Latches results into the E→M pipeline register that drives the memory stage's address, data, read and write selection. Also exposes combinational e_valE, e_dstE and e_cnd for forwarding and branch-misprediction logic.

---
 rtl/execute_stage_if.sv | 60 ++++++
 rtl/execute_stage.sv | 202 ++++++++++++++++++++
 tb/tb_execute_stage.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_if
// Purpose  : Signal bundle between the decode-side driver, the execute stage
//            and the memory stage: E-stage operands and pipeline control in,
//            forwarding taps, the E->M register and condition codes out.
// Revision : 1.0 - initial release
// ============================================================================
interface execute_stage_if;
    // Instruction currently in the execute stage
    logic [2:0]  E_stat;
    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [63:0] E_valA;
    logic [63:0] E_valB;
    logic [63:0] E_valC;
    logic [3:0]  E_dstE;
    logic [3:0]  E_dstM;

    // Pipeline control
    logic        set_cc_en;
    logic        M_stall;
    logic        M_bubble;

    // Combinational forwarding / branch taps
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic        e_cnd;

    // E->M pipeline register
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;

    // Condition codes {ZF,SF,OF}
    logic [2:0]  cc_out;

    // Upstream pipeline / environment side
    modport master (
        output E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
        output set_cc_en, M_stall, M_bubble,
        input  e_valE, e_dstE, e_cnd,
        input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
        input  cc_out
    );

    // Execute stage side
    modport slave (
        input  E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
        input  set_cc_en, M_stall, M_bubble,
        output e_valE, e_dstE, e_cnd,
        output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
        output cc_out
    );
endinterface
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Purpose  : Y86-64 execute stage. ALU for valE, jump/cmov condition against
//            the condition codes, CC update on OPq and the E->M register.
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage (
    input  wire logic        clk,
    input  wire logic        rst,
    execute_stage_if.slave   bus
);
    localparam logic [3:0] c_ICODE_NOP    = 4'h1;
    localparam logic [3:0] c_ICODE_CMOV   = 4'h2;
    localparam logic [3:0] c_ICODE_IRMOV  = 4'h3;
    localparam logic [3:0] c_ICODE_RMMOV  = 4'h4;
    localparam logic [3:0] c_ICODE_MRMOV  = 4'h5;
    localparam logic [3:0] c_ICODE_OPQ    = 4'h6;
    localparam logic [3:0] c_ICODE_JXX    = 4'h7;
    localparam logic [3:0] c_ICODE_CALL   = 4'h8;
    localparam logic [3:0] c_ICODE_RET    = 4'h9;
    localparam logic [3:0] c_ICODE_PUSH   = 4'hA;
    localparam logic [3:0] c_ICODE_POP    = 4'hB;
    localparam logic [3:0] c_REG_NONE     = 4'hF;
    localparam logic [2:0] c_STAT_AOK     = 3'd1;
    localparam logic [2:0] c_CC_RESET     = 3'b100;

    // ------------------------------------------------------------------
    // Combinational datapath signals
    // ------------------------------------------------------------------
    logic [63:0] w_alu_a;
    logic [63:0] w_alu_b;
    logic [63:0] w_val_e;
    logic        w_zf;
    logic        w_sf;
    logic        w_of;
    logic        w_cnd;
    logic [3:0]  w_dst_e;

    // Condition-code register
    logic [2:0]  cc_d;
    logic [2:0]  cc_q;

    // E->M register
    logic [2:0]  m_stat_d,  m_stat_q;
    logic [3:0]  m_icode_d, m_icode_q;
    logic        m_cnd_d,   m_cnd_q;
    logic [63:0] m_val_e_d, m_val_e_q;
    logic [63:0] m_val_a_d, m_val_a_q;
    logic [3:0]  m_dst_e_d, m_dst_e_q;
    logic [3:0]  m_dst_m_d, m_dst_m_q;

    // ALU operand selection and result; non-OPq icodes always add
    always_comb begin
        w_alu_a = 64'd0;
        w_alu_b = 64'd0;
        w_val_e = 64'd0;
        w_zf    = 1'b0;
        w_sf    = 1'b0;
        w_of    = 1'b0;
        case (bus.E_icode)
            c_ICODE_CMOV: begin
                w_alu_a = bus.E_valA;
                w_val_e = w_alu_a;
            end
            c_ICODE_IRMOV: begin
                w_alu_a = bus.E_valC;
                w_val_e = w_alu_a;
            end
            c_ICODE_RMMOV, c_ICODE_MRMOV: begin
                w_alu_a = bus.E_valC;
                w_alu_b = bus.E_valB;
                w_val_e = w_alu_b + w_alu_a;
            end
            c_ICODE_OPQ: begin
                w_alu_a = bus.E_valA;
                w_alu_b = bus.E_valB;
                case (bus.E_ifun)
                    4'h0: begin
                        w_val_e = w_alu_b + w_alu_a;
                        w_of    = (w_alu_a[63] == w_alu_b[63]) && (w_val_e[63] != w_alu_b[63]);
                    end
                    4'h1: begin
                        w_val_e = w_alu_b - w_alu_a;
                        w_of    = (w_alu_a[63] != w_alu_b[63]) && (w_val_e[63] != w_alu_b[63]);
                    end
                    4'h2:    w_val_e = w_alu_b & w_alu_a;
                    4'h3:    w_val_e = w_alu_b ^ w_alu_a;
                    default: w_val_e = 64'd0;
                endcase
                w_zf = (w_val_e == 64'd0);
                w_sf = w_val_e[63];
            end
            c_ICODE_CALL, c_ICODE_PUSH: begin
                w_alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
                w_alu_b = bus.E_valB;
                w_val_e = w_alu_b + w_alu_a;
            end
            c_ICODE_RET, c_ICODE_POP: begin
                w_alu_a = 64'd8;
                w_alu_b = bus.E_valB;
                w_val_e = w_alu_b + w_alu_a;
            end
            default: w_val_e = 64'd0;
        endcase
    end

    // Branch / cmov condition from the pre-update flags {ZF,SF,OF}
    always_comb begin
        w_cnd = 1'b1;
        if (bus.E_icode == c_ICODE_CMOV || bus.E_icode == c_ICODE_JXX) begin
            case (bus.E_ifun)
                4'h0:    w_cnd = 1'b1;
                4'h1:    w_cnd = (cc_q[1] ^ cc_q[0]) | cc_q[2];
                4'h2:    w_cnd = cc_q[1] ^ cc_q[0];
                4'h3:    w_cnd = cc_q[2];
                4'h4:    w_cnd = ~cc_q[2];
                4'h5:    w_cnd = ~(cc_q[1] ^ cc_q[0]);
                4'h6:    w_cnd = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
                default: w_cnd = 1'b0;
            endcase
        end
        w_dst_e = bus.E_dstE;
        if (bus.E_icode == c_ICODE_CMOV && !w_cnd) begin
            w_dst_e = c_REG_NONE;
        end
    end

    // CC next state: only valid OPq with permission and no stall writes flags
    always_comb begin
        cc_d = cc_q;
        if (bus.E_icode == c_ICODE_OPQ && bus.E_ifun <= 4'h3 &&
            bus.set_cc_en && !bus.M_stall) begin
            cc_d = {w_zf, w_sf, w_of};
        end
    end

    // E->M next state: bubble beats stall, stall holds, otherwise load
    always_comb begin
        m_stat_d  = m_stat_q;
        m_icode_d = m_icode_q;
        m_cnd_d   = m_cnd_q;
        m_val_e_d = m_val_e_q;
        m_val_a_d = m_val_a_q;
        m_dst_e_d = m_dst_e_q;
        m_dst_m_d = m_dst_m_q;
        if (bus.M_bubble) begin
            m_stat_d  = c_STAT_AOK;
            m_icode_d = c_ICODE_NOP;
            m_cnd_d   = 1'b0;
            m_val_e_d = 64'd0;
            m_val_a_d = 64'd0;
            m_dst_e_d = c_REG_NONE;
            m_dst_m_d = c_REG_NONE;
        end else if (!bus.M_stall) begin
            m_stat_d  = bus.E_stat;
            m_icode_d = bus.E_icode;
            m_cnd_d   = w_cnd;
            m_val_e_d = w_val_e;
            m_val_a_d = bus.E_valA;
            m_dst_e_d = w_dst_e;
            m_dst_m_d = bus.E_dstM;
        end
    end

    // State registers with synchronous reset to the bubble / initial CC value
    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q      <= c_CC_RESET;
            m_stat_q  <= c_STAT_AOK;
            m_icode_q <= c_ICODE_NOP;
            m_cnd_q   <= 1'b0;
            m_val_e_q <= 64'd0;
            m_val_a_q <= 64'd0;
            m_dst_e_q <= c_REG_NONE;
            m_dst_m_q <= c_REG_NONE;
        end else begin
            cc_q      <= cc_d;
            m_stat_q  <= m_stat_d;
            m_icode_q <= m_icode_d;
            m_cnd_q   <= m_cnd_d;
            m_val_e_q <= m_val_e_d;
            m_val_a_q <= m_val_a_d;
            m_dst_e_q <= m_dst_e_d;
            m_dst_m_q <= m_dst_m_d;
        end
    end

    assign bus.e_valE  = w_val_e;
    assign bus.e_dstE  = w_dst_e;
    assign bus.e_cnd   = w_cnd;
    assign bus.M_stat  = m_stat_q;
    assign bus.M_icode = m_icode_q;
    assign bus.M_cnd   = m_cnd_q;
    assign bus.M_valE  = m_val_e_q;
    assign bus.M_valA  = m_val_a_q;
    assign bus.M_dstE  = m_dst_e_q;
    assign bus.M_dstM  = m_dst_m_q;
    assign bus.cc_out  = cc_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage
// Purpose  : Directed self-checking bench for execute_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    execute_stage_if ex_if ();

    execute_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (ex_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction with default control (AOK, CC enabled, no stall/bubble)
    task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [3:0] dste, input logic [3:0] dstm);
        ex_if.E_stat    = 3'd1;
        ex_if.E_icode   = icode;
        ex_if.E_ifun    = ifun;
        ex_if.E_valA    = a;
        ex_if.E_valB    = b;
        ex_if.E_valC    = c;
        ex_if.E_dstE    = dste;
        ex_if.E_dstM    = dstm;
        ex_if.set_cc_en = 1'b1;
        ex_if.M_stall   = 1'b0;
        ex_if.M_bubble  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        step();
        step();
        rst = 1'b0;
        step();
        n_checks++; if (ex_if.M_icode !== 4'h1) begin n_fail++; $display("FAIL reset_icode: got %h expected 1", ex_if.M_icode); end
        n_checks++; if (ex_if.M_dstE !== 4'hF) begin n_fail++; $display("FAIL reset_dstE: got %h expected f", ex_if.M_dstE); end
        n_checks++; if (ex_if.M_dstM !== 4'hF) begin n_fail++; $display("FAIL reset_dstM: got %h expected f", ex_if.M_dstM); end
        n_checks++; if (ex_if.cc_out !== 3'b100) begin n_fail++; $display("FAIL reset_cc: got %b expected 100", ex_if.cc_out); end
        n_checks++; if (ex_if.M_stat !== 3'd1) begin n_fail++; $display("FAIL reset_stat: got %h expected 1", ex_if.M_stat); end
    endtask

    task automatic test_opq_add();
        drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h2, 4'hF);
        #1;
        n_checks++; if (ex_if.e_valE !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL add_valE: got %h expected 8000000000000000", ex_if.e_valE); end
        n_checks++; if (ex_if.e_dstE !== 4'h2) begin n_fail++; $display("FAIL add_dstE: got %h expected 2", ex_if.e_dstE); end
        step();
        n_checks++; if (ex_if.cc_out !== 3'b011) begin n_fail++; $display("FAIL add_cc: got %b expected 011", ex_if.cc_out); end
        n_checks++; if (ex_if.M_valE !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL add_MvalE: got %h expected 8000000000000000", ex_if.M_valE); end
        n_checks++; if (ex_if.M_icode !== 4'h6) begin n_fail++; $display("FAIL add_Micode: got %h expected 6", ex_if.M_icode); end
    endtask

    task automatic test_sub_cmov();
        drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2, 4'hF);
        #1;
        n_checks++; if (ex_if.e_valE !== 64'd0) begin n_fail++; $display("FAIL sub_valE: got %h expected 0", ex_if.e_valE); end
        step();
        n_checks++; if (ex_if.cc_out !== 3'b100) begin n_fail++; $display("FAIL sub_cc: got %b expected 100", ex_if.cc_out); end
        drive(4'h2, 4'h4, 64'h55, 64'd0, 64'd0, 4'h3, 4'hF);
        #1;
        n_checks++; if (ex_if.e_cnd !== 1'b0) begin n_fail++; $display("FAIL cmovne_cnd: got %b expected 0", ex_if.e_cnd); end
        n_checks++; if (ex_if.e_dstE !== 4'hF) begin n_fail++; $display("FAIL cmovne_dstE: got %h expected f", ex_if.e_dstE); end
        n_checks++; if (ex_if.e_valE !== 64'h55) begin n_fail++; $display("FAIL cmovne_valE: got %h expected 55", ex_if.e_valE); end
        step();
        n_checks++; if (ex_if.M_dstE !== 4'hF) begin n_fail++; $display("FAIL cmovne_MdstE: got %h expected f", ex_if.M_dstE); end
        n_checks++; if (ex_if.M_cnd !== 1'b0) begin n_fail++; $display("FAIL cmovne_Mcnd: got %b expected 0", ex_if.M_cnd); end
        n_checks++; if (ex_if.cc_out !== 3'b100) begin n_fail++; $display("FAIL cmovne_cc: got %b expected 100", ex_if.cc_out); end
    endtask

    task automatic test_mem_stack();
        drive(4'h4, 4'h0, 64'hAB, 64'h100, 64'h10, 4'hF, 4'hF);
        step();
        n_checks++; if (ex_if.M_valE !== 64'h110) begin n_fail++; $display("FAIL rmmovq_valE: got %h expected 110", ex_if.M_valE); end
        n_checks++; if (ex_if.M_valA !== 64'hAB) begin n_fail++; $display("FAIL rmmovq_valA: got %h expected ab", ex_if.M_valA); end
        n_checks++; if (ex_if.cc_out !== 3'b100) begin n_fail++; $display("FAIL rmmovq_cc: got %b expected 100", ex_if.cc_out); end
        drive(4'hA, 4'h0, 64'h1, 64'h200, 64'd0, 4'h4, 4'hF);
        step();
        n_checks++; if (ex_if.M_valE !== 64'h1F8) begin n_fail++; $display("FAIL pushq_valE: got %h expected 1f8", ex_if.M_valE); end
        n_checks++; if (ex_if.M_dstE !== 4'h4) begin n_fail++; $display("FAIL pushq_dstE: got %h expected 4", ex_if.M_dstE); end
        drive(4'hB, 4'h0, 64'h200, 64'h200, 64'd0, 4'h4, 4'h7);
        step();
        n_checks++; if (ex_if.M_valE !== 64'h208) begin n_fail++; $display("FAIL popq_valE: got %h expected 208", ex_if.M_valE); end
        n_checks++; if (ex_if.M_dstM !== 4'h7) begin n_fail++; $display("FAIL popq_dstM: got %h expected 7", ex_if.M_dstM); end
        drive(4'h3, 4'h0, 64'd0, 64'h999, 64'h1234, 4'h1, 4'hF);
        #1;
        n_checks++; if (ex_if.e_valE !== 64'h1234) begin n_fail++; $display("FAIL irmovq_valE: got %h expected 1234", ex_if.e_valE); end
        step();
    endtask

    task automatic test_set_cc_disable();
        drive(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h4, 4'hF);
        ex_if.set_cc_en = 1'b0;
        step();
        n_checks++; if (ex_if.M_valE !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL nocc_valE: got %h expected ffffffffffffffff", ex_if.M_valE); end
        n_checks++; if (ex_if.cc_out !== 3'b100) begin n_fail++; $display("FAIL nocc_cc: got %b expected 100", ex_if.cc_out); end
    endtask

    task automatic test_stall();
        drive(4'h6, 4'h3, 64'hF0, 64'h0F, 64'd0, 4'h5, 4'hF);
        ex_if.E_stat  = 3'd3;
        ex_if.M_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (ex_if.M_valE !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL stall_valE[%0d]: got %h expected ffffffffffffffff", i, ex_if.M_valE); end
            n_checks++; if (ex_if.M_dstE !== 4'h4) begin n_fail++; $display("FAIL stall_dstE[%0d]: got %h expected 4", i, ex_if.M_dstE); end
            n_checks++; if (ex_if.cc_out !== 3'b100) begin n_fail++; $display("FAIL stall_cc[%0d]: got %b expected 100", i, ex_if.cc_out); end
        end
        ex_if.M_stall = 1'b0;
        step();
        n_checks++; if (ex_if.M_valE !== 64'hFF) begin n_fail++; $display("FAIL release_valE: got %h expected ff", ex_if.M_valE); end
        n_checks++; if (ex_if.M_dstE !== 4'h5) begin n_fail++; $display("FAIL release_dstE: got %h expected 5", ex_if.M_dstE); end
        n_checks++; if (ex_if.M_stat !== 3'd3) begin n_fail++; $display("FAIL release_stat: got %h expected 3", ex_if.M_stat); end
        n_checks++; if (ex_if.cc_out !== 3'b000) begin n_fail++; $display("FAIL release_cc: got %b expected 000", ex_if.cc_out); end
    endtask

    task automatic test_bubble_stall();
        drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h6, 4'h2);
        ex_if.M_stall  = 1'b1;
        ex_if.M_bubble = 1'b1;
        step();
        n_checks++; if (ex_if.M_icode !== 4'h1) begin n_fail++; $display("FAIL bubble_icode: got %h expected 1", ex_if.M_icode); end
        n_checks++; if (ex_if.M_valE !== 64'd0) begin n_fail++; $display("FAIL bubble_valE: got %h expected 0", ex_if.M_valE); end
        n_checks++; if (ex_if.M_dstE !== 4'hF) begin n_fail++; $display("FAIL bubble_dstE: got %h expected f", ex_if.M_dstE); end
        n_checks++; if (ex_if.M_dstM !== 4'hF) begin n_fail++; $display("FAIL bubble_dstM: got %h expected f", ex_if.M_dstM); end
        n_checks++; if (ex_if.M_stat !== 3'd1) begin n_fail++; $display("FAIL bubble_stat: got %h expected 1", ex_if.M_stat); end
        n_checks++; if (ex_if.cc_out !== 3'b000) begin n_fail++; $display("FAIL bubble_cc: got %b expected 000", ex_if.cc_out); end
    endtask

    task automatic test_jle();
        // 0 - 1 = -1 gives ZF=0, SF=1, OF=0
        drive(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h2, 4'hF);
        step();
        n_checks++; if (ex_if.cc_out !== 3'b010) begin n_fail++; $display("FAIL neg_cc: got %b expected 010", ex_if.cc_out); end
        drive(4'h7, 4'h1, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF);
        #1;
        n_checks++; if (ex_if.e_cnd !== 1'b1) begin n_fail++; $display("FAIL jle_cnd: got %b expected 1", ex_if.e_cnd); end
        step();
        n_checks++; if (ex_if.M_cnd !== 1'b1) begin n_fail++; $display("FAIL jle_Mcnd: got %b expected 1", ex_if.M_cnd); end
        n_checks++; if (ex_if.M_icode !== 4'h7) begin n_fail++; $display("FAIL jle_Micode: got %h expected 7", ex_if.M_icode); end
        ex_if.E_ifun = 4'h3; #1;
        n_checks++; if (ex_if.e_cnd !== 1'b0) begin n_fail++; $display("FAIL je_cnd: got %b expected 0", ex_if.e_cnd); end
        ex_if.E_ifun = 4'h5; #1;
        n_checks++; if (ex_if.e_cnd !== 1'b0) begin n_fail++; $display("FAIL jge_cnd: got %b expected 0", ex_if.e_cnd); end
        ex_if.E_ifun = 4'h6; #1;
        n_checks++; if (ex_if.e_cnd !== 1'b0) begin n_fail++; $display("FAIL jg_cnd: got %b expected 0", ex_if.e_cnd); end
        ex_if.E_ifun = 4'h4; #1;
        n_checks++; if (ex_if.e_cnd !== 1'b1) begin n_fail++; $display("FAIL jne_cnd: got %b expected 1", ex_if.e_cnd); end
        ex_if.E_ifun = 4'h7; #1;
        n_checks++; if (ex_if.e_cnd !== 1'b0) begin n_fail++; $display("FAIL jbad_cnd: got %b expected 0", ex_if.e_cnd); end
        ex_if.E_icode = 4'h4; ex_if.E_ifun = 4'h3; #1;
        n_checks++; if (ex_if.e_cnd !== 1'b1) begin n_fail++; $display("FAIL nonbranch_cnd: got %b expected 1", ex_if.e_cnd); end
        step();
    endtask

    task automatic test_opq_invalid();
        drive(4'h6, 4'h4, 64'd3, 64'd3, 64'd0, 4'h2, 4'hF);
        #1;
        n_checks++; if (ex_if.e_valE !== 64'd0) begin n_fail++; $display("FAIL badop_valE: got %h expected 0", ex_if.e_valE); end
        step();
        n_checks++; if (ex_if.cc_out !== 3'b010) begin n_fail++; $display("FAIL badop_cc: got %b expected 010", ex_if.cc_out); end
    endtask

    task automatic test_sub_overflow();
        // 0x8000.. - 1 = 0x7FFF.. overflows: ZF=0, SF=0, OF=1
        drive(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'h2, 4'hF);
        #1;
        n_checks++; if (ex_if.e_valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL subov_valE: got %h expected 7fffffffffffffff", ex_if.e_valE); end
        step();
        n_checks++; if (ex_if.cc_out !== 3'b001) begin n_fail++; $display("FAIL subov_cc: got %b expected 001", ex_if.cc_out); end
        // Back-to-back: cmovl right after sees the freshly written flags
        drive(4'h2, 4'h2, 64'h77, 64'd0, 64'd0, 4'h3, 4'hF);
        #1;
        n_checks++; if (ex_if.e_cnd !== 1'b1) begin n_fail++; $display("FAIL cmovl_cnd: got %b expected 1", ex_if.e_cnd); end
        n_checks++; if (ex_if.e_dstE !== 4'h3) begin n_fail++; $display("FAIL cmovl_dstE: got %h expected 3", ex_if.e_dstE); end
        step();
    endtask

    task automatic test_and_flags();
        drive(4'h6, 4'h2, 64'hF0, 64'h0F, 64'd0, 4'h2, 4'hF);
        #1;
        n_checks++; if (ex_if.e_valE !== 64'd0) begin n_fail++; $display("FAIL and_valE: got %h expected 0", ex_if.e_valE); end
        step();
        n_checks++; if (ex_if.cc_out !== 3'b100) begin n_fail++; $display("FAIL and_cc: got %b expected 100", ex_if.cc_out); end
    endtask

    task automatic test_reset_mid();
        drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h2, 4'h3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (ex_if.cc_out !== 3'b100) begin n_fail++; $display("FAIL rstmid_cc: got %b expected 100", ex_if.cc_out); end
        n_checks++; if (ex_if.M_icode !== 4'h1) begin n_fail++; $display("FAIL rstmid_icode: got %h expected 1", ex_if.M_icode); end
        n_checks++; if (ex_if.M_dstM !== 4'hF) begin n_fail++; $display("FAIL rstmid_dstM: got %h expected f", ex_if.M_dstM); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        test_reset();
        test_opq_add();
        test_sub_cmov();
        test_mem_stack();
        test_set_cc_disable();
        test_stall();
        test_bubble_stall();
        test_jle();
        test_opq_invalid();
        test_sub_overflow();
        test_and_flags();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
